// File: rtl/cl_cfg_axil_pkg.sv
// rtl/cl_cfg_axil_pkg.sv - shared types and constants for the CL-side AXI-Lite config initiator
package cl_cfg_axil_pkg;

  // FSM states of the single-outstanding initiator
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_RSP     = 3'd6
  } cfg_axil_state_e;

  // AXI response codes; target responses pass through unmodified
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Handshake-control bundle of the AXI-Lite initiator port; payload
  // fields stay outside because their widths are per-instance parameters.
  typedef struct packed {
    logic awvalid;
    logic wvalid;
    logic bready;
    logic arvalid;
    logic rready;
  } axi_bus_t;

  // Width of a counter that must reach cycles-1
  function automatic int cnt_width(input int cycles);
    if (cycles <= 2) return 1;
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/cl_cfg_axil_master.sv
// rtl/cl_cfg_axil_master.sv - single-outstanding AXI4-Lite initiator with per-transaction timeout
module cl_cfg_axil_master
  import cl_cfg_axil_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rstn,
  // command stream
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  // response stream
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  // AW channel
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  // W channel
  output logic                    m_wvalid,
  input  logic                    m_wready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  // B channel
  input  logic                    m_bvalid,
  output logic                    m_bready,
  input  logic [1:0]              m_bresp,
  // AR channel
  output logic                    m_arvalid,
  input  logic                    m_arready,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  // R channel
  input  logic                    m_rvalid,
  output logic                    m_rready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp
);

  localparam int              CW       = cnt_width(TIMEOUT_CYCLES);
  localparam int              SW       = DATA_WIDTH / 8;
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  cfg_axil_state_e state_q, state_d;

  logic                  cmd_ready_q;
  logic                  is_write_q;
  logic                  aw_done_q, w_done_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0]         wstrb_q;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [1:0]            rsp_resp_q;
  logic                  rsp_timeout_q;

  axi_bus_t bus;

  logic accept;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic aw_done_d, w_done_d;
  logic in_timed;
  logic timed_out;
  logic timeout_fire;

  // Channel valid/ready decode; every term comes from a flop so no input
  // reaches an output combinationally.
  always_comb begin
    bus         = '0;
    bus.awvalid = (state_q == ST_WR_REQ) && !aw_done_q;
    bus.wvalid  = (state_q == ST_WR_REQ) && !w_done_q;
    bus.arvalid = (state_q == ST_RD_REQ);
    bus.bready  = (state_q == ST_WR_RESP) || ((state_q == ST_DRAIN) && is_write_q);
    bus.rready  = (state_q == ST_RD_RESP) || ((state_q == ST_DRAIN) && !is_write_q);
  end

  assign accept    = cmd_valid && cmd_ready_q;
  assign aw_hs     = bus.awvalid && m_awready;
  assign w_hs      = bus.wvalid  && m_wready;
  assign b_hs      = bus.bready  && m_bvalid;
  assign ar_hs     = bus.arvalid && m_arready;
  assign r_hs      = bus.rready  && m_rvalid;
  assign aw_done_d = aw_done_q || aw_hs;
  assign w_done_d  = w_done_q  || w_hs;

  // DRAIN is deliberately excluded: once abandoned, only a late response
  // (or reset) moves the block on.
  assign in_timed = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP) ||
                    (state_q == ST_RD_REQ) || (state_q == ST_RD_RESP);
  assign timed_out = in_timed && (cnt_q == CNT_LAST);

  // A real response arriving on the final timed cycle still wins.
  assign timeout_fire = timed_out && !b_hs && !r_hs;

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; on timeout a request phase whose address already
  // went out must wait in DRAIN so the late response is not mistaken for
  // the next transaction's.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = cmd_write ? ST_WR_REQ : ST_RD_REQ;
      end
      ST_WR_REQ: begin
        if (timed_out)                  state_d = aw_done_d ? ST_DRAIN : ST_RSP;
        else if (aw_done_d && w_done_d) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (b_hs)           state_d = ST_RSP;
        else if (timed_out) state_d = ST_DRAIN;
      end
      ST_RD_REQ: begin
        if (timed_out)  state_d = ar_hs ? ST_DRAIN : ST_RSP;
        else if (ar_hs) state_d = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        if (r_hs)           state_d = ST_RSP;
        else if (timed_out) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (b_hs || r_hs) state_d = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command capture, per-channel done flags and the timeout counter
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cmd_ready_q <= 1'b0;
      is_write_q  <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      cnt_q       <= '0;
    end else begin
      cmd_ready_q <= (state_d == ST_IDLE);
      if (accept) begin
        is_write_q <= cmd_write;
        addr_q     <= cmd_addr;
        wdata_q    <= cmd_wdata;
        wstrb_q    <= cmd_wstrb;
        aw_done_q  <= 1'b0;
        w_done_q   <= 1'b0;
        cnt_q      <= '0;
      end else begin
        aw_done_q <= aw_done_d;
        w_done_q  <= w_done_d;
        if (in_timed) cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  // Response capture; a late response absorbed in DRAIN leaves the
  // timeout result untouched.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= RESP_OKAY;
      rsp_timeout_q <= 1'b0;
    end else if (timeout_fire) begin
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= RESP_SLVERR;
      rsp_timeout_q <= 1'b1;
    end else if (b_hs && (state_q == ST_WR_RESP)) begin
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= m_bresp;
      rsp_timeout_q <= 1'b0;
    end else if (r_hs && (state_q == ST_RD_RESP)) begin
      rsp_rdata_q   <= m_rdata;
      rsp_resp_q    <= m_rresp;
      rsp_timeout_q <= 1'b0;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = (state_q == ST_RSP);
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_timeout = rsp_timeout_q;

  assign m_awvalid = bus.awvalid;
  assign m_wvalid  = bus.wvalid;
  assign m_bready  = bus.bready;
  assign m_arvalid = bus.arvalid;
  assign m_rready  = bus.rready;
  assign m_awaddr  = addr_q;
  assign m_araddr  = addr_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;

endmodule

// File: tb/tb_cl_cfg_axil_master.sv
// tb/tb_cl_cfg_axil_master.sv - self-checking bench for cl_cfg_axil_master
module tb_cl_cfg_axil_master;
  import cl_cfg_axil_pkg::*;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        m_awvalid, m_awready = 1'b0;
  logic [31:0] m_awaddr;
  logic        m_wvalid, m_wready = 1'b0;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_bvalid = 1'b0, m_bready;
  logic [1:0]  m_bresp = '0;
  logic        m_arvalid, m_arready = 1'b0;
  logic [31:0] m_araddr;
  logic        m_rvalid = 1'b0, m_rready;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rresp = '0;

  cl_cfg_axil_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad = 0;
  int last_c0 = 0;

  // target behaviour knobs, set by the stimulus
  int da = 0, dw = 0, db = 0, dar = 0, dr = 0;
  logic [1:0]  t_bresp = '0, t_rresp = '0;
  logic [31:0] t_rdata = '0;

  // target bookkeeping
  logic aw_got = 1'b0, w_got = 1'b0, ar_got = 1'b0;
  int aw_seen = 0, w_seen = 0, ar_seen = 0, b_wait = 0, r_wait = 0;
  int aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, r_hs_n = 0;
  int aw_hs_cyc = 0, w_hs_cyc = 0, order_bad = 0;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
  logic [3:0]  cap_wstrb = '0;

  // Delay-programmable AXI-Lite target; handshakes are those where valid and
  // ready are both high at this falling edge (they complete at the next rise).
  always @(negedge clk) begin
    if (!rstn) begin
      aw_got = 0; w_got = 0; ar_got = 0;
      aw_seen = 0; w_seen = 0; ar_seen = 0; b_wait = 0; r_wait = 0;
      m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
    end else begin
      if (rsp_valid) begin
        aw_got = 0; w_got = 0; ar_got = 0; b_wait = 0; r_wait = 0;
      end
      if (m_bready && !(aw_got && w_got)) order_bad++;
      if (m_rready && !ar_got) order_bad++;
      m_bvalid = aw_got && w_got && (b_wait >= db);
      m_bresp  = t_bresp;
      if (aw_got && w_got) b_wait++;
      if (m_bvalid && m_bready) begin
        b_hs_n++; aw_got = 0; w_got = 0; b_wait = 0;
      end
      m_rvalid = ar_got && (r_wait >= dr);
      m_rdata  = t_rdata;
      m_rresp  = t_rresp;
      if (ar_got) r_wait++;
      if (m_rvalid && m_rready) begin
        r_hs_n++; ar_got = 0; r_wait = 0;
      end
      m_awready = m_awvalid && (aw_seen >= da);
      if (m_awvalid && m_awready) begin
        aw_got = 1; aw_hs_n++; aw_hs_cyc = cyc; cap_awaddr = m_awaddr;
      end
      aw_seen = m_awvalid ? aw_seen + 1 : 0;
      m_wready = m_wvalid && (w_seen >= dw);
      if (m_wvalid && m_wready) begin
        w_got = 1; w_hs_n++; w_hs_cyc = cyc; cap_wdata = m_wdata; cap_wstrb = m_wstrb;
      end
      w_seen = m_wvalid ? w_seen + 1 : 0;
      m_arready = m_arvalid && (ar_seen >= dar);
      if (m_arvalid && m_arready) begin
        ar_got = 1; ar_hs_n++; cap_araddr = m_araddr;
      end
      ar_seen = m_arvalid ? ar_seen + 1 : 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    total++;
    bad++;
    $error("FAIL %s: observed no event expected event within cycle budget", tag);
  endtask

  // Reference: cycle numbers relative to accept (cycle 0). Requests go out
  // in cycle 1, the response channel opens the cycle after the last request
  // handshake, the last timed cycle is T, and after a timeout a request that
  // already left waits for its late response.
  task automatic model(input logic wr, input int d_req, input int d_w, input int d_rsp,
                       output int lat, output logic tmo);
    int req_c, done_c, rsp_c;
    req_c  = 1 + d_req;
    done_c = (wr && (d_w > d_req)) ? 1 + d_w : req_c;
    rsp_c  = done_c + 1 + d_rsp;
    if (done_c < T && rsp_c <= T) begin
      lat = rsp_c + 1; tmo = 1'b0;
    end else if (req_c <= T) begin
      lat = ((rsp_c > T + 1) ? rsp_c : T + 1) + 1; tmo = 1'b1;
    end else begin
      lat = T + 1; tmo = 1'b1;
    end
  endtask

  task automatic run_cmd(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb,
                         input logic [1:0] er, input logic [31:0] ed, input logic et,
                         input int elat, input int bp);
    logic got;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      if (cmd_ready) begin got = 1'b1; last_c0 = cyc; end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    if (!got) begin bound_fail({tag, "_accept"}); return; end
    got = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      if (rsp_valid) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin bound_fail({tag, "_rsp"}); return; end
    chk({tag, "_latency"}, 64'(cyc - last_c0), 64'(elat));
    chk({tag, "_resp"}, {62'd0, rsp_resp}, {62'd0, er});
    chk({tag, "_rdata"}, {32'd0, rsp_rdata}, {32'd0, ed});
    chk({tag, "_timeout"}, {63'd0, rsp_timeout}, {63'd0, et});
    chk({tag, "_bus_idle"}, {59'd0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 64'd0);
    if (!et) begin
      if (wr) begin
        chk({tag, "_awaddr"}, {32'd0, cap_awaddr}, {32'd0, addr});
        chk({tag, "_wdata"}, {28'd0, cap_wstrb, cap_wdata}, {28'd0, strb, data});
      end else begin
        chk({tag, "_araddr"}, {32'd0, cap_araddr}, {32'd0, addr});
      end
    end
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk({tag, "_hold"}, {29'd0, rsp_valid, rsp_timeout, rsp_resp, rsp_rdata},
          {29'd0, 1'b1, et, er, ed});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_ready_after"}, {62'd0, cmd_ready, rsp_valid}, 64'd2);
  endtask

  initial begin
    int lat, extra, n_aw, n_w, n_b;
    logic tmo, got;
    logic wr;
    int dreq, dwr, drsp, bp;
    logic [1:0]  rc;
    logic [31:0] a, d, rd;
    logic [3:0]  s;

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {55'd0, cmd_ready, rsp_valid, rsp_timeout, rsp_resp,
                       m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 64'd0);
    chk("reset_data", {rsp_rdata, m_awaddr}, 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("reset_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    // zero-wait write
    da = 0; dw = 0; db = 0; t_bresp = RESP_OKAY;
    model(1'b1, 0, 0, 0, lat, tmo);
    run_cmd("zw_wr", 1'b1, 32'h0000_7004, 32'hDEAD_BEEF, 4'hF, RESP_OKAY, 32'd0, tmo, lat, 0);
    chk("zw_aw_cycle", 64'(aw_hs_cyc - last_c0), 64'd1);
    chk("zw_w_cycle", 64'(w_hs_cyc - last_c0), 64'd1);

    // skewed write: AW late, W immediate
    n_aw = aw_hs_n; n_w = w_hs_n; n_b = b_hs_n;
    da = 5; dw = 0; t_bresp = RESP_EXOKAY;
    model(1'b1, 5, 0, 0, lat, tmo);
    run_cmd("skew_wr", 1'b1, 32'h0000_7008, 32'h0BAD_F00D, 4'h3, RESP_EXOKAY, 32'd0, tmo, lat, 1);
    chk("skew_counts", {40'd0, 8'(aw_hs_n - n_aw), 8'(w_hs_n - n_w), 8'(b_hs_n - n_b)}, 64'h01_01_01);
    chk("skew_w_first", {63'd0, (w_hs_cyc < aw_hs_cyc)}, 64'd1);
    chk("skew_b_order", 64'(order_bad), 64'd0);
    da = 0;

    // read with response backpressure
    dar = 0; dr = 0; t_rdata = 32'h1234_5678; t_rresp = RESP_DECERR;
    model(1'b0, 0, 0, 0, lat, tmo);
    run_cmd("bp_rd", 1'b0, 32'h0000_700C, 32'd0, 4'h0, RESP_DECERR, 32'h1234_5678, tmo, lat, 4);

    // read timeout, AR never accepted
    dar = 100;
    model(1'b0, 100, 0, 0, lat, tmo);
    run_cmd("tmo_rd", 1'b0, 32'h0000_7010, 32'd0, 4'h0, RESP_SLVERR, 32'd0, tmo, lat, 0);
    chk("tmo_rd_latency_abs", 64'(lat), 64'(T + 1));
    dar = 0;

    // write timeout with a late B absorbed by DRAIN
    n_b = b_hs_n; db = 40; t_bresp = RESP_OKAY;
    model(1'b1, 0, 0, 40, lat, tmo);
    run_cmd("late_b", 1'b1, 32'h0000_7014, 32'h5555_AAAA, 4'hF, RESP_SLVERR, 32'd0, tmo, lat, 0);
    chk("late_b_absorbed", 64'(b_hs_n - n_b), 64'd1);
    db = 0;
    extra = 0;
    repeat (5) begin @(negedge clk); if (rsp_valid) extra++; end
    chk("late_b_single_rsp", 64'(extra), 64'd0);
    model(1'b1, 0, 0, 0, lat, tmo);
    run_cmd("after_drain", 1'b1, 32'h0000_7018, 32'hCAFE_0001, 4'h5, RESP_OKAY, 32'd0, tmo, lat, 0);

    // reset while waiting in WR_RESP
    db = 10;
    cmd_write = 1'b1; cmd_addr = 32'h0000_701C; cmd_wdata = 32'h1111_2222; cmd_wstrb = 4'hF;
    cmd_valid = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      if (cmd_ready) got = 1'b1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      if (m_bready) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) bound_fail("rst_wr_reach_resp");
    rstn = 1'b0;
    @(negedge clk);
    chk("rst_wr_ctrl", {57'd0, rsp_valid, cmd_ready,
                        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 64'd0);
    chk("rst_wr_data", {m_awaddr, m_wdata}, 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_wr_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    db = 0;
    extra = 0;
    repeat (15) begin @(negedge clk); if (rsp_valid) extra++; end
    chk("rst_wr_no_rsp", 64'(extra), 64'd0);
    t_rdata = 32'hA5A5_0F0F; t_rresp = RESP_OKAY;
    model(1'b0, 0, 0, 0, lat, tmo);
    run_cmd("post_rst_rd", 1'b0, 32'h0000_7020, 32'd0, 4'h0, RESP_OKAY, 32'hA5A5_0F0F, tmo, lat, 0);

    // randomized traffic against the reference
    for (int i = 0; i < 40; i++) begin
      wr   = 1'($urandom_range(0, 1));
      dreq = ($urandom_range(0, 4) == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 4));
      dwr  = int'($urandom_range(0, 4));
      drsp = ($urandom_range(0, 4) == 0) ? int'($urandom_range(8, 30)) : int'($urandom_range(0, 4));
      rc   = 2'($urandom_range(0, 3));
      a    = $urandom & 32'hFFFF_FFFC;
      d    = $urandom;
      rd   = $urandom;
      s    = 4'($urandom_range(0, 15));
      bp   = int'($urandom_range(0, 3));
      if (wr) begin
        da = dreq; dw = dwr; db = drsp; t_bresp = rc;
      end else begin
        dar = dreq; dr = drsp; t_rresp = rc; t_rdata = rd;
      end
      model(wr, dreq, dwr, drsp, lat, tmo);
      run_cmd(wr ? "rnd_wr" : "rnd_rd", wr, a, d, s,
              tmo ? RESP_SLVERR : rc, (tmo || wr) ? 32'd0 : rd, tmo, lat, bp);
    end
    chk("rnd_order", 64'(order_bad), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
